fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_buffer.sv | 52 +++++
 rtl/fetch_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types, widths and PC check for the fetch controller
// Rev 1.0
// ============================================================================
package fetch_pkg;

  localparam int XLEN          = 64;
  localparam int ILEN          = 32;
  localparam int WORD_SIZE_POW = 2;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  // A PC may be fetched only if it is word aligned and below the memory limit
  function automatic logic pc_is_fetchable(input logic [XLEN-1:0] pc,
                                           input logic [XLEN-1:0] limit);
    return (pc[WORD_SIZE_POW-1:0] == '0) && (pc < limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// fetch_buffer : small circular FIFO of {pc, inst} entries with flush
// Rev 1.0
// ============================================================================
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: count gates every read of it
  always_ff @(posedge clk) begin
    if (!reset && !flush && push) entries[wr_ptr] <= push_entry;
  end

  assign head = entries[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// fetch_controller : sequential instruction fetch with redirect and fault halt
// Rev 1.0
// ============================================================================
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC      = 64'h0,
  parameter int          MEM_DEPTH_POW = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect_valid_in,
  input  logic [XLEN-1:0]  redirect_pc_in,
  output logic [XLEN-1:0]  imem_addr_out,
  input  logic [ILEN-1:0]  imem_data_in,
  output logic             inst_valid_out,
  input  logic             inst_ready_in,
  output logic [ILEN-1:0]  inst_out,
  output logic [XLEN-1:0]  inst_pc_out,
  output logic             fault_out,
  output logic [XLEN-1:0]  fault_pc_out
);

  localparam int              BUF_DEPTH = 2;
  localparam int              CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam logic [XLEN-1:0] MEM_LIMIT = 64'd1 << (MEM_DEPTH_POW + WORD_SIZE_POW);
  localparam logic [XLEN-1:0] LAST_WORD = MEM_LIMIT - 64'd4;

  fetch_state_t     state;
  fetch_state_t     state_nxt;
  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_nxt;
  logic [XLEN-1:0]  fault_pc;
  logic [XLEN-1:0]  fault_pc_nxt;

  logic             flush;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      fault_pc <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      fault_pc <= fault_pc_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    fault_pc_nxt = fault_pc;
    flush        = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;

    if (redirect_valid_in) begin
      flush  = 1'b1;
      pc_nxt = redirect_pc_in;
      if (pc_is_fetchable(redirect_pc_in, MEM_LIMIT)) begin
        state_nxt = FETCH;
      end else begin
        state_nxt    = FAULT;
        fault_pc_nxt = redirect_pc_in;
      end
    end else begin
      pop = (count != '0) && inst_ready_in;
      case (state)
        FETCH: begin
          // Only a bad RESET_PC can leave an unfetchable PC in FETCH
          if (!pc_is_fetchable(pc, MEM_LIMIT)) begin
            state_nxt    = FAULT;
            fault_pc_nxt = pc;
          end else if ((count != CNT_W'(BUF_DEPTH)) || pop) begin
            push   = 1'b1;
            pc_nxt = pc + 64'd4;
            if (pc == LAST_WORD) begin
              state_nxt    = FAULT;
              fault_pc_nxt = MEM_LIMIT;
            end
          end
        end
        FAULT: begin
        end
        default: begin
          state_nxt = FETCH;
        end
      endcase
    end
  end

  assign push_entry = '{pc: pc, inst: imem_data_in};

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

  assign imem_addr_out  = pc;
  assign inst_valid_out = (count != '0);
  assign inst_out       = head.inst;
  assign inst_pc_out    = head.pc;
  assign fault_out      = (state == FAULT);
  assign fault_pc_out   = fault_pc;

endmodule
`default_nettype wire
